// File: rtl/float2int_pipe.sv
// Three-stage IEEE-754 single to int32 converter: unpack, align, round/sign/saturate.
// Sticky saturation counter and NaN flag are cleared by a run pulse.
module float2int_pipe #(
  parameter int unsigned DATA_W = 32,  // only 32 is legal
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic              valid_out,
  output logic [CNT_W-1:0]  sat_count,
  output logic              nan_seen
);

  localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MaxNeg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CntMax = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Stage 1: unpack
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  logic        s1_sign;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;
  logic        s1_nan;
  logic        s1_inf;
  logic        s1_frac_zero;

  logic [7:0]  in_exp;
  logic [22:0] in_frac;

  assign in_exp  = in0[30:23];
  assign in_frac = in0[22:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_exp       <= '0;
      s1_mant      <= '0;
      s1_nan       <= 1'b0;
      s1_inf       <= 1'b0;
      s1_frac_zero <= 1'b0;
    end else begin
      s1_valid     <= valid_in;
      s1_sign      <= in0[31];
      s1_exp       <= in_exp;
      s1_mant      <= {(in_exp != 8'd0), in_frac};
      s1_nan       <= (in_exp == 8'hFF) && (in_frac != 23'd0);
      s1_inf       <= (in_exp == 8'hFF) && (in_frac == 23'd0);
      s1_frac_zero <= (in_frac == 23'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: align
  // ---------------------------------------------------------------------------
  logic signed [9:0]  exp_unb;
  logic [4:0]         shr_amt;
  logic [3:0]         shl_amt;
  logic [47:0]        shr_val;
  logic               a_ovf;
  logic [DATA_W-1:0]  a_mag;
  logic               a_guard;
  logic               a_sticky;

  assign exp_unb = $signed({2'b00, s1_exp}) - 10'sd127;

  always_comb begin
    a_ovf    = 1'b0;
    a_mag    = '0;
    a_guard  = 1'b0;
    a_sticky = 1'b0;
    shr_amt  = '0;
    shl_amt  = '0;
    shr_val  = '0;

    if (s1_inf) begin
      a_ovf = 1'b1;
    end else if (!s1_nan && (exp_unb >= 10'sd31)) begin
      // -2^31 is the one value with e==31 that fits
      a_ovf = !(s1_sign && (exp_unb == 10'sd31) && s1_frac_zero);
    end

    if (exp_unb <= -10'sd2) begin
      a_sticky = |s1_mant;
    end else if (exp_unb <= 10'sd23) begin
      // Mantissa sits above 24 zero bits so guard/sticky fall out of the low half
      shr_amt  = 5'(10'sd23 - exp_unb);
      shr_val  = {s1_mant, 24'd0} >> shr_amt;
      a_mag    = {8'd0, shr_val[47:24]};
      a_guard  = shr_val[23];
      a_sticky = |shr_val[22:0];
    end else begin
      // Only e in 24..31 matters here; larger exponents are already ovf
      shl_amt = 4'(exp_unb - 10'sd23);
      a_mag   = {8'd0, s1_mant} << shl_amt;
    end
  end

  logic              s2_valid;
  logic              s2_sign;
  logic              s2_nan;
  logic              s2_ovf;
  logic [DATA_W-1:0] s2_mag;
  logic              s2_guard;
  logic              s2_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_mag    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_ovf    <= a_ovf;
      s2_mag    <= a_mag;
      s2_guard  <= a_guard;
      s2_sticky <= a_sticky;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: round, sign, saturate
  // ---------------------------------------------------------------------------
  logic              round_inc;
  logic [DATA_W-1:0] rounded;
  logic [DATA_W-1:0] result;

  assign round_inc = s2_guard && (s2_sticky || s2_mag[0]);
  assign rounded   = s2_mag + {{(DATA_W-1){1'b0}}, round_inc};

  always_comb begin
    result = '0;
    if (s2_nan) begin
      result = '0;
    end else if (s2_ovf) begin
      result = s2_sign ? MaxNeg : MaxPos;
    end else if (s2_sign) begin
      result = -rounded;
    end else begin
      result = rounded;
    end
  end

  logic             sat_hit;
  logic             nan_hit;
  logic [CNT_W-1:0] sat_count_d;
  logic             nan_seen_d;

  assign sat_hit = s2_valid && s2_ovf;
  assign nan_hit = s2_valid && s2_nan;

  always_comb begin
    sat_count_d = sat_count;
    nan_seen_d  = nan_seen;
    if (run) begin
      sat_count_d = sat_hit ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      nan_seen_d  = nan_hit;
    end else begin
      if (sat_hit && (sat_count != CntMax)) begin
        sat_count_d = sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (nan_hit) begin
        nan_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0      <= '0;
      valid_out <= 1'b0;
      sat_count <= '0;
      nan_seen  <= 1'b0;
    end else begin
      valid_out <= s2_valid;
      if (s2_valid) begin
        out0 <= result;
      end
      sat_count <= sat_count_d;
      nan_seen  <= nan_seen_d;
    end
  end

endmodule

// File: tb/tb_float2int_pipe.sv
// Directed bench for float2int_pipe: rounding, saturation, specials, gaps, status, reset.
module tb_float2int_pipe;

  logic        clk;
  logic        rst;
  logic        run;
  logic        valid_in;
  logic [31:0] in0;
  logic [31:0] out0;
  logic        valid_out;
  logic [15:0] sat_count;
  logic        nan_seen;

  int n_checks = 0;
  int n_errors = 0;

  float2int_pipe #(
    .DATA_W(32),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .valid_in (valid_in),
    .in0      (in0),
    .out0     (out0),
    .valid_out(valid_out),
    .sat_count(sat_count),
    .nan_seen (nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One operand; valid_out must stay low two cycles and rise on the third
  task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] exp);
    @(negedge clk);
    valid_in = 1'b1;
    in0      = f;
    @(negedge clk);
    valid_in = 1'b0;
    in0      = 32'hDEADBEEF;
    check({tag, "_lat1"}, {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    check({tag, "_lat2"}, {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_value"}, out0, exp);
  endtask

  logic        pat [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] flt [8]  = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

  initial begin
    int          fi;
    int          oi;
    logic        ev;
    logic [31:0] last;

    rst      = 1'b1;
    run      = 1'b0;
    valid_in = 1'b0;
    in0      = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_out0", out0, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_sat", {16'd0, sat_count}, 32'd0);
    check("rst_nan", {31'd0, nan_seen}, 32'd0);
    rst = 1'b0;

    // Rounding
    convert("r1p5", 32'h3FC00000, 32'd2);
    convert("r2p5", 32'h40200000, 32'd2);
    convert("rm1p5", 32'hBFC00000, 32'hFFFFFFFE);
    convert("r0p5", 32'h3F000000, 32'd0);
    convert("r0p5ulp", 32'h3F000001, 32'd1);
    @(negedge clk);
    check("hold_valid", {31'd0, valid_out}, 32'd0);
    check("hold_out0", out0, 32'd1);

    // Saturation and specials
    convert("pos2_31", 32'h4F000000, 32'h7FFFFFFF);
    check("pos2_31_sat", {16'd0, sat_count}, 32'd1);
    convert("neg2_31", 32'hCF000000, 32'h80000000);
    check("neg2_31_sat", {16'd0, sat_count}, 32'd1);
    convert("neginf", 32'hFF800000, 32'h80000000);
    check("neginf_sat", {16'd0, sat_count}, 32'd2);
    check("neginf_nan", {31'd0, nan_seen}, 32'd0);
    convert("nan", 32'h7FC00000, 32'd0);
    check("nan_flag", {31'd0, nan_seen}, 32'd1);
    check("nan_sat", {16'd0, sat_count}, 32'd2);
    convert("denorm", 32'h00000001, 32'd0);
    convert("negzero", 32'h80000000, 32'd0);
    convert("m0p4", 32'hBECCCCCD, 32'd0);
    convert("f42", 32'h42280000, 32'd42);

    // run alone clears status
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("run_sat", {16'd0, sat_count}, 32'd0);
    check("run_nan", {31'd0, nan_seen}, 32'd0);

    // run coinciding with a saturating result leaves exactly that event
    convert("pre_run", 32'h4F000000, 32'h7FFFFFFF);
    check("pre_run_sat", {16'd0, sat_count}, 32'd1);
    @(negedge clk);
    valid_in = 1'b1;
    in0      = 32'h4F000000;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("runhit_valid", {31'd0, valid_out}, 32'd1);
    check("runhit_sat", {16'd0, sat_count}, 32'd1);

    // Streaming with gaps
    fi   = 0;
    oi   = 0;
    last = 32'h7FFFFFFF;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      ev = (k >= 3 && k < 13) ? pat[k-3] : 1'b0;
      check($sformatf("strm_v%0d", k), {31'd0, valid_out}, {31'd0, ev});
      if (ev) begin
        check($sformatf("strm_d%0d", k), out0, oi);
        last = oi;
        oi++;
      end else begin
        check($sformatf("strm_h%0d", k), out0, last);
      end
      if (k < 10 && pat[k]) begin
        valid_in = 1'b1;
        in0      = flt[fi];
        fi++;
      end else begin
        valid_in = 1'b0;
        in0      = 32'h12345678;
      end
    end
    check("strm_count", oi, 32'd8);

    // Counter saturation
    @(negedge clk);
    valid_in = 1'b1;
    in0      = 32'h4F000000;
    repeat (70000) @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_max", {16'd0, sat_count}, 32'h0000FFFF);

    // Async reset with operands in flight
    @(negedge clk);
    valid_in = 1'b1;
    in0      = 32'h3F800000;
    @(negedge clk);
    in0 = 32'h40000000;
    @(negedge clk);
    in0 = 32'h40400000;
    @(negedge clk);
    valid_in = 1'b0;
    check("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    check("pre_rst_out0", out0, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    check("arst_out0", out0, 32'd0);
    check("arst_sat", {16'd0, sat_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_v%0d", k), {31'd0, valid_out}, 32'd0);
    end
    convert("post_rst42", 32'h42280000, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
